// File: rtl/updown_counter_div_pkg.sv
// Shared definitions for the up/down counter with built-in prescaler.
// Mode encodings for the SATURATE parameter and a constant-foldable clog2.
package updown_counter_div_pkg;

  localparam int unsigned CNT_MODE_WRAP = 0;
  localparam int unsigned CNT_MODE_SAT  = 1;

  function automatic int unsigned clog2(input longint unsigned value);
    int unsigned     result;
    longint unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/updown_counter_div_tick_gen.sv
// Free-running prescaler: emits a one-cycle enable pulse every PRESCALE clocks.
// With PRESCALE=1 the compare value is 0, so tick stays high permanently.
module tick_gen
  import updown_counter_div_pkg::*;
#(
  parameter int unsigned PRESCALE = 5000000,
  parameter int unsigned PS_WIDTH = 26
) (
  input  logic clk,
  input  logic clr,
  output logic tick
);

  if (PS_WIDTH < clog2(longint'(PRESCALE))) begin : g_bad_ps_width
    $error("PS_WIDTH too small for PRESCALE");
  end
  if (PRESCALE < 1) begin : g_bad_prescale
    $error("PRESCALE must be at least 1");
  end

  localparam logic [PS_WIDTH-1:0] PsLast = PS_WIDTH'(PRESCALE - 1);

  logic [PS_WIDTH-1:0] ps_q, ps_d;

  always_comb begin
    ps_d = ps_q + PS_WIDTH'(1);
    if (ps_q == PsLast) begin
      ps_d = '0;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      ps_q <= '0;
    end else begin
      ps_q <= ps_d;
    end
  end

  assign tick = (ps_q == PsLast);

endmodule

// File: rtl/updown_counter_div.sv
// Up/down modulo-N counter with prescaler, load/clear, wrap or saturate mode,
// terminal count, wrap pulse and a strobe-latched output register.
module updown_counter_div
  import updown_counter_div_pkg::*;
#(
  parameter int unsigned      WIDTH    = 8,
  parameter longint unsigned  MODULUS  = 64'd1 << WIDTH,
  parameter int unsigned      PRESCALE = 5000000,
  parameter int unsigned      PS_WIDTH = 26,
  parameter int unsigned      SATURATE = CNT_MODE_WRAP
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             sclr,
  input  logic             load,
  input  logic [WIDTH-1:0] data_in,
  input  logic             cnt_en,
  input  logic             up,
  input  logic             latch,
  output logic [WIDTH-1:0] cnt,
  output logic [WIDTH-1:0] q,
  output logic             tick,
  output logic             tc,
  output logic             wrap
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("WIDTH must be in 1..32");
  end
  if (MODULUS < 2 || MODULUS > (64'd1 << WIDTH)) begin : g_bad_modulus
    $error("MODULUS must satisfy 2 <= MODULUS <= 2**WIDTH");
  end
  if (SATURATE != CNT_MODE_WRAP && SATURATE != CNT_MODE_SAT) begin : g_bad_mode
    $error("SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] CntMax     = WIDTH'(MODULUS - 1);
  localparam bit               Saturating = (SATURATE == CNT_MODE_SAT);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             wrap_q, wrap_d;
  logic             at_max, at_min;

  tick_gen #(
    .PRESCALE (PRESCALE),
    .PS_WIDTH (PS_WIDTH)
  ) u_tick_gen (
    .clk  (clk),
    .clr  (clr),
    .tick (tick)
  );

  assign at_max = (cnt_q == CntMax);
  assign at_min = (cnt_q == '0);

  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    if (sclr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = (data_in > CntMax) ? CntMax : data_in;
    end else if (tick && cnt_en) begin
      if (up) begin
        if (!at_max) begin
          cnt_d = cnt_q + WIDTH'(1);
        end else if (!Saturating) begin
          cnt_d  = '0;
          wrap_d = 1'b1;
        end
      end else begin
        if (!at_min) begin
          cnt_d = cnt_q - WIDTH'(1);
        end else if (!Saturating) begin
          cnt_d  = CntMax;
          wrap_d = 1'b1;
        end
      end
    end
  end

  // q samples the pre-edge count, so a simultaneous step/load/clear is not seen.
  always_comb begin
    q_d = q_q;
    if (latch) begin
      q_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cnt_q  <= '0;
      q_q    <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      q_q    <= q_d;
      wrap_q <= wrap_d;
    end
  end

  assign cnt  = cnt_q;
  assign q    = q_q;
  assign wrap = wrap_q;
  assign tc   = cnt_en & ((up & at_max) | (~up & at_min));

endmodule

// File: tb/tb_updown_counter_div.sv
// Directed bench: wrap-mode counter (MODULUS=10, PRESCALE=4) plus saturate-mode
// instances with PRESCALE=4 and PRESCALE=1 sharing one stimulus set.
module tb_updown_counter_div;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clr;
  logic       m_sclr, m_load, m_en, m_up, m_latch;
  logic [7:0] m_data, m_cnt, m_q;
  logic       m_tick, m_tc, m_wrap;
  logic       s_sclr, s_load, s_en, s_up, s_latch;
  logic [7:0] s_data, s_cnt, s_q, p_cnt, p_q;
  logic       s_tick, s_tc, s_wrap, p_tick, p_tc, p_wrap;

  int n_checks = 0;
  int n_pass   = 0;
  int sat_wrap_seen = 0;

  updown_counter_div #(
    .WIDTH(8), .MODULUS(10), .PRESCALE(4), .PS_WIDTH(3), .SATURATE(0)
  ) dut_m (
    .clk(clk), .clr(clr), .sclr(m_sclr), .load(m_load), .data_in(m_data),
    .cnt_en(m_en), .up(m_up), .latch(m_latch), .cnt(m_cnt), .q(m_q),
    .tick(m_tick), .tc(m_tc), .wrap(m_wrap)
  );

  updown_counter_div #(
    .WIDTH(8), .MODULUS(10), .PRESCALE(4), .PS_WIDTH(3), .SATURATE(1)
  ) dut_s (
    .clk(clk), .clr(clr), .sclr(s_sclr), .load(s_load), .data_in(s_data),
    .cnt_en(s_en), .up(s_up), .latch(s_latch), .cnt(s_cnt), .q(s_q),
    .tick(s_tick), .tc(s_tc), .wrap(s_wrap)
  );

  updown_counter_div #(
    .WIDTH(8), .MODULUS(10), .PRESCALE(1), .PS_WIDTH(1), .SATURATE(1)
  ) dut_p (
    .clk(clk), .clr(clr), .sclr(s_sclr), .load(s_load), .data_in(s_data),
    .cnt_en(s_en), .up(s_up), .latch(s_latch), .cnt(p_cnt), .q(p_q),
    .tick(p_tick), .tc(p_tc), .wrap(p_wrap)
  );

  always @(posedge clk) begin
    if (s_wrap === 1'b1 || p_wrap === 1'b1) sat_wrap_seen <= sat_wrap_seen + 1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Advance until the saturate instance shows tick, so the next edge steps it.
  task automatic align_s();
    int n;
    n = 0;
    while (s_tick !== 1'b1 && n < 8) begin
      step(1);
      n++;
    end
    check("align_s_tick", 32'(s_tick), 1);
  endtask

  initial begin
    clr = 1'b0;
    {m_sclr, m_load, m_en, m_up, m_latch} = '0;
    {s_sclr, s_load, s_en, s_up, s_latch} = '0;
    m_data = '0;
    s_data = '0;

    step(2);
    check("rst_cnt", 32'(m_cnt), 0);
    check("rst_q", 32'(m_q), 0);
    check("rst_wrap", 32'(m_wrap), 0);
    check("rst_tick", 32'(m_tick), 0);
    check("rst_tc", 32'(m_tc), 0);

    // Up count and wrap; edge index counted from release.
    m_en = 1'b1;
    m_up = 1'b1;
    clr  = 1'b1;
    step(3);
    check("first_tick_pending", 32'(m_cnt), 0);
    check("tick_high", 32'(m_tick), 1);
    step(1);
    check("first_step", 32'(m_cnt), 1);
    check("tick_one_cycle", 32'(m_tick), 0);
    for (int k = 2; k <= 9; k++) begin
      step(4);
      check("up_count", 32'(m_cnt), 32'(k));
    end
    check("tc_at_9", 32'(m_tc), 1);
    check("no_wrap_yet", 32'(m_wrap), 0);
    step(4);
    check("up_wrap_cnt", 32'(m_cnt), 0);
    check("up_wrap_pulse", 32'(m_wrap), 1);
    step(1);
    check("wrap_one_cycle", 32'(m_wrap), 0);

    // Latch coherence at edge 68 (cnt 6 -> 7).
    step(23);
    check("pre_latch_cnt", 32'(m_cnt), 6);
    step(3);
    m_latch = 1'b1;
    step(1);
    check("latch_q_old", 32'(m_q), 6);
    check("latch_cnt_new", 32'(m_cnt), 7);
    m_latch = 1'b0;
    step(4);
    check("q_holds", 32'(m_q), 6);
    check("cnt_advances", 32'(m_cnt), 8);

    // Load clamp, sclr priority, non-tick load.
    m_load = 1'b1;
    m_data = 8'h2A;
    step(1);
    check("load_clamp", 32'(m_cnt), 9);
    check("tc_after_load", 32'(m_tc), 1);
    m_data = 8'd3;
    m_sclr = 1'b1;
    step(1);
    check("sclr_over_load", 32'(m_cnt), 0);
    check("sclr_no_wrap", 32'(m_wrap), 0);
    m_sclr = 1'b0;
    step(1);
    check("load_non_tick", 32'(m_cnt), 3);

    // Down wrap; edge 76 is a tick edge but load wins.
    m_data = 8'd0;
    m_up   = 1'b0;
    step(1);
    check("load_over_step", 32'(m_cnt), 0);
    m_load = 1'b0;
    check("tc_at_0_down", 32'(m_tc), 1);
    step(4);
    check("down_wrap_cnt", 32'(m_cnt), 9);
    check("down_wrap_pulse", 32'(m_wrap), 1);
    step(1);
    check("down_wrap_one_cycle", 32'(m_wrap), 0);
    m_en = 1'b0;
    m_up = 1'b1;
    #1;
    check("tc_gated_by_en", 32'(m_tc), 0);
    step(8);
    check("hold_disabled", 32'(m_cnt), 9);

    // Asynchronous reset mid-operation.
    m_load = 1'b1;
    m_data = 8'd5;
    step(1);
    m_load  = 1'b0;
    m_latch = 1'b1;
    step(1);
    m_latch = 1'b0;
    check("pre_reset_q", 32'(m_q), 5);
    #3;
    clr = 1'b0;
    #1;
    check("async_rst_cnt", 32'(m_cnt), 0);
    check("async_rst_q", 32'(m_q), 0);
    check("async_rst_tick", 32'(m_tick), 0);
    m_en = 1'b1;
    m_up = 1'b1;
    step(1);
    clr = 1'b1;
    step(3);
    check("rerelease_no_step", 32'(m_cnt), 0);
    step(1);
    check("rerelease_step", 32'(m_cnt), 1);

    // Saturate mode, PRESCALE=4 and PRESCALE=1.
    s_load = 1'b1;
    s_data = 8'd9;
    s_up   = 1'b1;
    s_en   = 1'b1;
    step(1);
    s_load = 1'b0;
    check("sat_load", 32'(s_cnt), 9);
    check("sat_tc_up", 32'(s_tc), 1);
    check("ps1_tick", 32'(p_tick), 1);
    align_s();
    step(1);
    check("sat_hold_max", 32'(s_cnt), 9);
    check("ps1_hold_max", 32'(p_cnt), 9);
    s_up   = 1'b0;
    s_load = 1'b1;
    s_data = 8'd0;
    step(1);
    s_load = 1'b0;
    check("sat_tc_down", 32'(s_tc), 1);
    align_s();
    step(1);
    check("sat_hold_min", 32'(s_cnt), 0);
    check("ps1_hold_min", 32'(p_cnt), 0);
    s_up = 1'b1;
    step(1);
    check("ps1_step1", 32'(p_cnt), 1);
    step(1);
    check("ps1_step2", 32'(p_cnt), 2);
    check("ps1_tick_held", 32'(p_tick), 1);
    step(1);
    check("sat_never_wrap", 32'(sat_wrap_seen), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
